divider: RTL

Sequential 32-bit shift-subtract (restoring) divider for the MIPS datapath, one quotient bit per clock. It executes DIVU, and DIV when signed support is compiled in. It is the inverse companion of the shift-add multiplier and sits beside it on the HI/LO path. Results are packed {remainder, quotient} into a 64-bit word so HI and LO load with the same slicing as a multiply.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 28 ++
 rtl/divider.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// +-----------------------------------------------------------------------+
// | div_pkg : shared types and constants for the restoring divider        |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package div_pkg;

   localparam int DATA_W    = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 6;

   localparam logic [DATA_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } div_state_t;

   function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                                input logic              neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +-----------------------------------------------------------------------+
// | div_step : one restoring shift-subtract iteration (combinational)     |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module div_step
   import div_pkg::*;
(
   input  logic [DATA_W-1:0] rem,
   input  logic              dvd_msb,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_next,
   output logic              q_bit
);

   // One extra bit keeps the shifted remainder exact for divisors >= 2^31.
   logic [DATA_W:0]   w_shifted;
   logic [DATA_W-1:0] w_diff;

   assign w_shifted = {rem, dvd_msb};
   assign q_bit     = (w_shifted >= {1'b0, divisor});
   assign w_diff    = w_shifted[DATA_W-1:0] - divisor;
   assign rem_next  = q_bit ? w_diff : w_shifted[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/divider.sv
// +-----------------------------------------------------------------------+
// | divider : 32-bit restoring divider, one quotient bit per clock        |
// | Optional signed DIV support with macro SIGNED_DIV_EN. Revision : 1.0  |
// +-----------------------------------------------------------------------+
`default_nettype none

module divider
   import div_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     dataA,
   input  logic [DATA_W-1:0]     dataB,
   input  logic                  divOp,
   input  logic                  signedOp,
   output logic [2*DATA_W-1:0]   dataOut,
   output logic                  busy,
   output logic                  done
);

   div_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_dvd;
   logic [DATA_W-1:0] r_dvs;
   logic [DATA_W-1:0] r_quo;

   logic [DATA_W-1:0] w_a_mag;
   logic [DATA_W-1:0] w_b_mag;
   logic [DATA_W-1:0] w_rem_next;
   logic [DATA_W-1:0] w_quo_next;
   logic [DATA_W-1:0] w_rem_fin;
   logic [DATA_W-1:0] w_quo_fin;
   logic              w_qbit;

   div_step u_step (
      .rem      (r_rem),
      .dvd_msb  (r_dvd[DATA_W-1]),
      .divisor  (r_dvs),
      .rem_next (w_rem_next),
      .q_bit    (w_qbit)
   );

   assign w_quo_next = {r_quo[DATA_W-2:0], w_qbit};

`ifdef SIGNED_DIV_EN
   logic r_neg_q;
   logic r_neg_r;
   logic w_a_neg;
   logic w_b_neg;

   assign w_a_neg   = signedOp & dataA[DATA_W-1];
   assign w_b_neg   = signedOp & dataB[DATA_W-1];
   assign w_a_mag   = neg_if(dataA, w_a_neg);
   assign w_b_mag   = neg_if(dataB, w_b_neg);
   // Quotient sign follows the operand sign mismatch; remainder follows the dividend.
   assign w_quo_fin = neg_if(w_quo_next, r_neg_q);
   assign w_rem_fin = neg_if(w_rem_next, r_neg_r);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == IDLE && divOp && dataB != '0) begin
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
      end
   end
`else
   logic w_unused_signed;

   assign w_unused_signed = signedOp;
   assign w_a_mag         = dataA;
   assign w_b_mag         = dataB;
   assign w_quo_fin       = w_quo_next;
   assign w_rem_fin       = w_rem_next;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_quo   <= '0;
         dataOut <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (divOp) begin
                  if (dataB == '0) begin
                     dataOut <= {dataA, DIV0_QUOTIENT};
                     done    <= 1'b1;
                  end else begin
                     r_rem   <= '0;
                     r_quo   <= '0;
                     r_dvd   <= w_a_mag;
                     r_dvs   <= w_b_mag;
                     r_cnt   <= '0;
                     busy    <= 1'b1;
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               r_rem <= w_rem_next;
               r_dvd <= {r_dvd[DATA_W-2:0], 1'b0};
               r_quo <= w_quo_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
                  dataOut <= {w_rem_fin, w_quo_fin};
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
